// File: rtl/mem_byte_sequencer.sv
// Byte-serial RAM access sequencer for the multicycle CPU: big-endian byte/half/word reads and writes.
// Optional build macro MEMSEQ_SIGN_EXT_EN enables sign extension of byte/half reads.
module mem_byte_sequencer #(
   parameter int ADDR_W = 9,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mov,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              moc,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [7:0]        ram_rdata,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR       = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_mov_q;
   logic              r_err;
   logic [1:0]        r_size;
   logic [1:0]        r_last;
   logic [1:0]        r_idx;
   logic [1:0]        r_lat_cnt;
   logic [ADDR_W-1:0] r_base;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rbuf;
   logic [31:0]       r_data_out;

   logic              w_accept;
   logic              w_valid;
   logic [1:0]        w_last_in;
   logic              w_lat_done;
   logic              w_last_byte;
   logic [1:0]        w_sel;
   logic [31:0]       w_rbuf_nxt;
   logic [31:0]       w_rd_result;
   logic [23:0]       w_fill_b;
   logic [15:0]       w_fill_h;

`ifdef MEMSEQ_SIGN_EXT_EN
   logic              r_sext;
   assign w_fill_b = {24{r_sext & w_rbuf_nxt[7]}};
   assign w_fill_h = {16{r_sext & w_rbuf_nxt[15]}};
`else
   logic              w_unused_sext;
   assign w_unused_sext = sign_ext;
   assign w_fill_b = 24'd0;
   assign w_fill_h = 16'd0;
`endif

   // Only a rising edge of mov seen in IDLE starts an access; held or busy-time pulses are dropped.
   assign w_accept    = (r_state == S_IDLE) && mov && !r_mov_q;
   assign w_lat_done  = (r_lat_cnt == 2'(RD_LAT - 1));
   assign w_last_byte = (r_idx == r_last);

   always_comb begin
      w_valid   = (mem_read != mem_write);
      w_last_in = 2'd0;
      case (size)
         2'b00: w_last_in = 2'd0;
         2'b01: begin
            w_last_in = 2'd1;
            if (address[0]) w_valid = 1'b0;
         end
         2'b10: begin
            w_last_in = 2'd3;
            if (address[1:0] != 2'b00) w_valid = 1'b0;
         end
         default: w_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_valid)      w_next = S_DONE;
               else if (mem_read) w_next = S_RD_ISSUE;
               else               w_next = S_WR;
            end
         end
         S_RD_ISSUE: w_next = S_RD_WAIT;
         S_RD_WAIT: begin
            if (w_lat_done) w_next = w_last_byte ? S_DONE : S_RD_ISSUE;
         end
         S_WR: begin
            if (w_last_byte) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Bytes shift in MSB-first, so after N captures the result is already right-justified.
   assign w_rbuf_nxt = {r_rbuf[23:0], ram_rdata};

   always_comb begin
      case (r_size)
         2'b00:   w_rd_result = {w_fill_b, w_rbuf_nxt[7:0]};
         2'b01:   w_rd_result = {w_fill_h, w_rbuf_nxt[15:0]};
         default: w_rd_result = w_rbuf_nxt;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_mov_q    <= 1'b0;
         r_err      <= 1'b0;
         r_size     <= 2'd0;
         r_last     <= 2'd0;
         r_idx      <= 2'd0;
         r_lat_cnt  <= 2'd0;
         r_base     <= '0;
         r_wdata    <= 32'd0;
         r_rbuf     <= 32'd0;
         r_data_out <= 32'd0;
`ifdef MEMSEQ_SIGN_EXT_EN
         r_sext     <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_mov_q <= mov;
         if (w_accept) begin
            r_err   <= !w_valid;
            r_size  <= size;
            r_last  <= w_last_in;
            r_base  <= address;
            r_wdata <= data_in;
            r_idx   <= 2'd0;
            r_rbuf  <= 32'd0;
`ifdef MEMSEQ_SIGN_EXT_EN
            r_sext  <= sign_ext;
`endif
         end
         if (r_state == S_RD_ISSUE) begin
            r_lat_cnt <= 2'd0;
         end else if (r_state == S_RD_WAIT && !w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
         end
         if (r_state == S_RD_WAIT && w_lat_done) begin
            r_rbuf <= w_rbuf_nxt;
            if (w_last_byte) r_data_out <= w_rd_result;
            else             r_idx      <= r_idx + 2'd1;
         end
         if (r_state == S_WR && !w_last_byte) r_idx <= r_idx + 2'd1;
      end
   end

   // Write byte i takes field byte N-1-i of the right-justified data.
   assign w_sel     = r_last - r_idx;
   assign ram_wdata = (r_state == S_WR) ? r_wdata[{w_sel, 3'b000} +: 8] : 8'd0;
   assign ram_addr  = r_base + ADDR_W'(r_idx);
   assign ram_re    = (r_state == S_RD_ISSUE);
   assign ram_we    = (r_state == S_WR);
   assign moc       = (r_state == S_DONE);
   assign err       = (r_state == S_DONE) && r_err;
   assign busy      = (r_state == S_RD_ISSUE) || (r_state == S_RD_WAIT) || (r_state == S_WR);
   assign data_out  = r_data_out;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a 512x8 RAM model (read latency 1).
module tb_mem_byte_sequencer;

   localparam int ADDR_W = 9;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              mov = 1'b0;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic [1:0]        size = 2'b00;
   logic              sign_ext = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [31:0]       data_in = 32'd0;
   logic [31:0]       data_out;
   logic              moc;
   logic              busy;
   logic              err;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic              ram_we;
   logic              ram_re;
   logic [7:0]        ram_rdata = 8'd0;
   logic [2:0]        dbg_state;

   logic [7:0]        mem [512];
   logic              pre_we = 1'b0;
   logic [8:0]        pre_addr = 9'd0;
   logic [7:0]        pre_data = 8'd0;
   logic [16:0]       wr_log [$];
   logic [8:0]        rd_log [$];
   logic              both_seen = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   mem_byte_sequencer #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
      .clock     (clock),
      .reset     (reset),
      .mov       (mov),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .size      (size),
      .sign_ext  (sign_ext),
      .address   (address),
      .data_in   (data_in),
      .data_out  (data_out),
      .moc       (moc),
      .busy      (busy),
      .err       (err),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_rdata (ram_rdata),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   // RAM model: writes and preloads land on the edge, reads return one edge after ram_re.
   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] = pre_data;
      if (ram_we) begin
         mem[ram_addr] = ram_wdata;
         wr_log.push_back({ram_addr, ram_wdata});
      end
      if (ram_re) begin
         ram_rdata <= mem[ram_addr];
         rd_log.push_back(ram_addr);
      end
      if (ram_re && ram_we) both_seen = 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [8:0] a, input logic [7:0] v);
      @(negedge clock);
      pre_addr = a;
      pre_data = v;
      pre_we   = 1'b1;
      @(negedge clock);
      pre_we   = 1'b0;
   endtask

   // lat = rising edges after the accepting edge until moc is seen (0 = cycle right after accept).
   task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [8:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic b0);
      @(negedge clock);
      mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; address = a; data_in = d;
      mov = 1'b1;
      @(posedge clock);
      lat = -1; e = 1'b0; b0 = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (c == 0) b0 = busy;
         if (moc) begin
            lat = c;
            e   = err;
            break;
         end
      end
      mov = 1'b0;
   endtask

   initial begin
      int lat;
      logic e, b0;
      int w0, r0, moc_cnt;
      logic [31:0] exp_b, exp_h;
      logic [8:0] inv_a [4];
      logic [1:0] inv_sz [4];
      logic inv_rd [4];
      logic inv_wr [4];

      // reset held low while preloading
      preload(9'd0, 8'h24); preload(9'd1, 8'h01); preload(9'd2, 8'h00); preload(9'd3, 8'h2C);
      preload(9'd5, 8'h80);
      preload(9'd16, 8'h11); preload(9'd17, 8'h22); preload(9'd18, 8'h33); preload(9'd19, 8'h44);
      @(negedge clock);
      check_val("rst_data_out", data_out, 32'd0);
      check_val("rst_moc", {31'd0, moc}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_err", {31'd0, err}, 32'd0);
      check_val("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check_val("rst_ram_re", {31'd0, ram_re}, 32'd0);
      check_val("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
      check_val("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // word read @0
      r0 = rd_log.size();
      run_req(1'b1, 1'b0, 2'b10, 1'b0, 9'd0, 32'd0, lat, e, b0);
      check_val("rd_word_lat", lat, 32'd8);
      check_val("rd_word_err", {31'd0, e}, 32'd0);
      check_val("rd_word_busy", {31'd0, b0}, 32'd1);
      check_val("rd_word_data", data_out, 32'h2401002C);
      check_val("rd_word_nrd", rd_log.size() - r0, 32'd4);
      for (int k = 0; k < 4; k++) check_val("rd_word_addr", {23'd0, rd_log[r0 + k]}, k);
      @(negedge clock);
      check_val("moc_one_cycle", {31'd0, moc}, 32'd0);

      // word write @8
      w0 = wr_log.size();
      run_req(1'b0, 1'b1, 2'b10, 1'b0, 9'd8, 32'hDEADBEEF, lat, e, b0);
      check_val("wr_word_lat", lat, 32'd4);
      check_val("wr_word_err", {31'd0, e}, 32'd0);
      check_val("wr_word_nwr", wr_log.size() - w0, 32'd4);
      check_val("wr_word_b0", {15'd0, wr_log[w0 + 0]}, {15'd0, 9'd8, 8'hDE});
      check_val("wr_word_b1", {15'd0, wr_log[w0 + 1]}, {15'd0, 9'd9, 8'hAD});
      check_val("wr_word_b2", {15'd0, wr_log[w0 + 2]}, {15'd0, 9'd10, 8'hBE});
      check_val("wr_word_b3", {15'd0, wr_log[w0 + 3]}, {15'd0, 9'd11, 8'hEF});
      check_val("wr_word_keep_dout", data_out, 32'h2401002C);

      // byte and half reads with sign_ext requested
`ifdef MEMSEQ_SIGN_EXT_EN
      exp_b = 32'hFFFFFF80;
      exp_h = 32'hFFFFBEEF;
`else
      exp_b = 32'h00000080;
      exp_h = 32'h0000BEEF;
`endif
      run_req(1'b1, 1'b0, 2'b00, 1'b1, 9'd5, 32'd0, lat, e, b0);
      check_val("rd_byte_lat", lat, 32'd2);
      check_val("rd_byte_sx", data_out, exp_b);
      run_req(1'b1, 1'b0, 2'b00, 1'b0, 9'd5, 32'd0, lat, e, b0);
      check_val("rd_byte_zx", data_out, 32'h00000080);
      run_req(1'b1, 1'b0, 2'b01, 1'b1, 9'd10, 32'd0, lat, e, b0);
      check_val("rd_half_lat", lat, 32'd4);
      check_val("rd_half_sx", data_out, exp_h);

      // half write at the top of the address space
      w0 = wr_log.size();
      run_req(1'b0, 1'b1, 2'b01, 1'b0, 9'd510, 32'h0000A55A, lat, e, b0);
      check_val("wr_half_lat", lat, 32'd2);
      check_val("wr_half_nwr", wr_log.size() - w0, 32'd2);
      check_val("wr_half_b0", {15'd0, wr_log[w0 + 0]}, {15'd0, 9'd510, 8'hA5});
      check_val("wr_half_b1", {15'd0, wr_log[w0 + 1]}, {15'd0, 9'd511, 8'h5A});

      // invalid requests: misaligned half, misaligned word, size 11, rd==wr
      inv_a  = '{9'd3, 9'd6, 9'd0, 9'd0};
      inv_sz = '{2'b01, 2'b10, 2'b11, 2'b10};
      inv_rd = '{1'b1, 1'b0, 1'b1, 1'b1};
      inv_wr = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         w0 = wr_log.size();
         r0 = rd_log.size();
         run_req(inv_rd[k], inv_wr[k], inv_sz[k], 1'b0, inv_a[k], 32'h12345678, lat, e, b0);
         check_val("inv_lat", lat, 32'd0);
         check_val("inv_err", {31'd0, e}, 32'd1);
         check_val("inv_strobes", (wr_log.size() - w0) + (rd_log.size() - r0), 32'd0);
         check_val("inv_dout", data_out, exp_h);
      end
      run_req(1'b0, 1'b0, 2'b00, 1'b0, 9'd0, 32'd0, lat, e, b0);
      check_val("inv_none_err", {31'd0, e}, 32'd1);

      // re-pulse while busy, then mov held high past DONE
      r0 = rd_log.size();
      moc_cnt = 0;
      lat = -1;
      @(negedge clock);
      mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; address = 9'd8; mov = 1'b1;
      @(posedge clock);
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (c == 1) mov = 1'b0;
         if (c == 2) mov = 1'b1;
         if (moc) begin
            moc_cnt++;
            if (lat < 0) lat = c;
         end
      end
      mov = 1'b0;
      check_val("busy_repulse_lat", lat, 32'd8);
      check_val("busy_repulse_nmoc", moc_cnt, 32'd1);
      check_val("busy_repulse_nrd", rd_log.size() - r0, 32'd4);
      check_val("busy_repulse_data", data_out, 32'hDEADBEEF);

      // reset during byte 2 of a word write @16
      @(negedge clock);
      mem_read = 1'b0; mem_write = 1'b1; size = 2'b10; address = 9'd16; data_in = 32'hCAFEF00D;
      mov = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check_val("midrst_we", {31'd0, ram_we}, 32'd0);
      check_val("midrst_busy", {31'd0, busy}, 32'd0);
      mov = 1'b0;
      moc_cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (moc) moc_cnt++;
      end
      check_val("midrst_nmoc", moc_cnt, 32'd0);
      check_val("midrst_m16", {24'd0, mem[16]}, 32'h000000CA);
      check_val("midrst_m17", {24'd0, mem[17]}, 32'h000000FE);
      check_val("midrst_m18", {24'd0, mem[18]}, 32'h00000033);
      check_val("midrst_m19", {24'd0, mem[19]}, 32'h00000044);
      check_val("midrst_dout", data_out, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      check_val("re_we_exclusive", {31'd0, both_seen}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
